// File: rtl/div_pkg.sv
// Shared types and constants for the divider launch controller.
package div_pkg;
    localparam int DIV_W  = 32;
    localparam int DIV_LW = 5;
    localparam logic [DIV_W-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        LAUNCH,
        WAIT,
        RESP
    } div_launch_state_t;
endpackage

// File: rtl/div_launch_ctrl_if.sv
// Operand intake, divider launch/completion and result port of div_launch_ctrl.
interface div_launch_ctrl_if;
    import div_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DIV_W-1:0]  in_dividend;
    logic [DIV_W-1:0]  in_divisor;
    logic              div_start;
    logic [DIV_W-1:0]  div_dividend;
    logic [DIV_W-1:0]  div_divisor;
    logic [DIV_LW-1:0] div_m;
    logic [DIV_LW-1:0] div_n;
    logic              div_done;
    logic [DIV_W-1:0]  div_quotient;
    logic [DIV_W-1:0]  div_rem;
    logic              out_valid;
    logic              out_ready;
    logic [DIV_W-1:0]  out_quotient;
    logic [DIV_W-1:0]  out_rem;
    logic              div_by_zero;
    logic              range_err;

    // Controller side
    modport slave (
        input  in_valid, in_dividend, in_divisor, div_done, div_quotient, div_rem, out_ready,
        output in_ready, div_start, div_dividend, div_divisor, div_m, div_n,
               out_valid, out_quotient, out_rem, div_by_zero, range_err
    );

    // Environment side: operand producer, divider and result consumer
    modport master (
        output in_valid, in_dividend, in_divisor, div_done, div_quotient, div_rem, out_ready,
        input  in_ready, div_start, div_dividend, div_divisor, div_m, div_n,
               out_valid, out_quotient, out_rem, div_by_zero, range_err
    );
endinterface

// File: rtl/div_launch_ctrl_msb_scan.sv
// Leading-one finder: shifts a working copy left until bit 31 is set,
// decrementing the bit index from 31 on each shift.
module msb_scan
    import div_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [DIV_W-1:0]  din,
    output logic              found,
    output logic [DIV_LW-1:0] idx
);
    logic [DIV_W-1:0]  work_q, work_d;
    logic [DIV_LW-1:0] idx_q, idx_d;

    assign found = work_q[DIV_W-1];
    assign idx   = idx_q;

    always_comb begin
        work_d = work_q;
        idx_d  = idx_q;
        if (load) begin
            work_d = din;
            idx_d  = '1;
        end else if (step && !found) begin
            work_d = work_q << 1;
            idx_d  = idx_q - DIV_LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work_q <= '0;
            idx_q  <= '0;
        end else begin
            work_q <= work_d;
            idx_q  <= idx_d;
        end
    end
endmodule

// File: rtl/div_launch_ctrl.sv
// Front end for the sequential divider: screens special cases, finds operand
// MSB positions, launches the divider and holds its result for the consumer.
module div_launch_ctrl
    import div_pkg::*;
#(
    parameter int W  = DIV_W,
    parameter int LW = DIV_LW
) (
    input logic clk,
    input logic rst,
    div_launch_ctrl_if.slave bus
);
    div_launch_state_t state_q, state_d;
    logic [W-1:0]  dvd_q, dvd_d, dvs_q, dvs_d;
    logic [W-1:0]  quo_q, quo_d, rem_q, rem_d;
    logic          dbz_q, dbz_d, rerr_q, rerr_d;
    logic          scan_load, scan_step;
    logic          m_found, n_found;
    logic [LW-1:0] m_idx, n_idx;

    msb_scan u_scan_m (
        .clk(clk), .rst(rst), .load(scan_load), .step(scan_step),
        .din(bus.in_dividend), .found(m_found), .idx(m_idx)
    );

    msb_scan u_scan_n (
        .clk(clk), .rst(rst), .load(scan_load), .step(scan_step),
        .din(bus.in_divisor), .found(n_found), .idx(n_idx)
    );

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        rerr_d    = rerr_q;
        scan_load = 1'b0;
        scan_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dvd_d     = bus.in_dividend;
                    dvs_d     = bus.in_divisor;
                    scan_load = 1'b1;
                    // Screening order matters: zero divisor outranks range error
                    if (bus.in_divisor == '0) begin
                        dbz_d   = 1'b1;
                        quo_d   = DIV_ZERO_Q;
                        rem_d   = bus.in_dividend;
                        state_d = RESP;
                    end else if (bus.in_dividend[W-1]) begin
                        rerr_d  = 1'b1;
                        quo_d   = '0;
                        rem_d   = bus.in_dividend;
                        state_d = RESP;
                    end else if (bus.in_dividend < bus.in_divisor) begin
                        quo_d   = '0;
                        rem_d   = bus.in_dividend;
                        state_d = RESP;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                scan_step = 1'b1;
                if (m_found && n_found) state_d = LAUNCH;
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
                if (bus.div_done) begin
                    quo_d   = bus.div_quotient;
                    rem_d   = bus.div_rem;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.out_ready) begin
                    dbz_d   = 1'b0;
                    rerr_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            rerr_q  <= rerr_d;
        end
    end

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.div_start    = (state_q == LAUNCH);
    assign bus.div_dividend = dvd_q;
    assign bus.div_divisor  = dvs_q;
    assign bus.div_m        = m_idx;
    assign bus.div_n        = n_idx;
    assign bus.out_valid    = (state_q == RESP);
    assign bus.out_quotient = quo_q;
    assign bus.out_rem      = rem_q;
    assign bus.div_by_zero  = dbz_q;
    assign bus.range_err    = rerr_q;
endmodule

// File: tb/tb_div_launch_ctrl.sv
// Scoreboard bench for div_launch_ctrl with a fixed-latency divider model.
module tb_div_launch_ctrl;
    localparam int DIV_LAT = 4;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic        rerr;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb[$];

    logic        model_en;
    logic        mdl_done;
    logic [31:0] mdl_q, mdl_r;
    logic        stale_done;

    div_launch_ctrl_if bus();

    div_launch_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.div_done     = mdl_done | stale_done;
    assign bus.div_quotient = stale_done ? 32'hDEAD_BEEF : mdl_q;
    assign bus.div_rem      = stale_done ? 32'h0BAD_F00D : mdl_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic int msb(input logic [31:0] x);
        for (int i = 31; i >= 0; i--) if (x[i]) return i;
        return 0;
    endfunction

    // Divider model: answers DIV_LAT cycles after the start pulse
    initial begin
        logic [31:0] a, b;
        mdl_done = 1'b0;
        mdl_q    = '0;
        mdl_r    = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.div_start && model_en) begin
                a = bus.div_dividend;
                b = bus.div_divisor;
                repeat (DIV_LAT) @(posedge clk);
                #1;
                mdl_done = 1'b1;
                mdl_q    = a / b;
                mdl_r    = a % b;
                @(posedge clk); #1;
                mdl_done = 1'b0;
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        int   c, start_cyc, m, n;
        logic special;
        special = 1'b1;
        e.dbz = 1'b0; e.rerr = 1'b0;
        if (b == 0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1;
        end else if (a[31]) begin
            e.q = 0; e.r = a; e.rerr = 1'b1;
        end else if (a < b) begin
            e.q = 0; e.r = a;
        end else begin
            e.q = a / b; e.r = a % b; special = 1'b0;
        end
        sb.push_back(e);
        m = msb(a);
        n = msb(b);

        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid    = 1'b1;
        bus.in_dividend = a;
        bus.in_divisor  = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        c = 1;
        start_cyc = -1;
        while (c < 400 && !bus.out_valid) begin
            if (bus.div_start) begin
                start_cyc = c;
                chk("div_m", 32'(bus.div_m), 32'(m));
                chk("div_n", 32'(bus.div_n), 32'(n));
                chk("div_dividend", bus.div_dividend, a);
                chk("div_divisor", bus.div_divisor, b);
            end
            @(posedge clk); #1;
            c++;
        end
        chk("out_valid_seen", 32'(bus.out_valid), 32'd1);
        if (special) begin
            chk("special_valid_cyc", c, 32'd1);
            chk("special_no_start", start_cyc, -1);
        end else begin
            chk("start_cyc", start_cyc, ((31 - m) > (31 - n) ? (31 - m) : (31 - n)) + 2);
        end

        e = sb.pop_front();
        for (int h = 0; h <= hold; h++) begin
            chk("out_quotient", bus.out_quotient, e.q);
            chk("out_rem", bus.out_rem, e.r);
            chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
            chk("range_err", 32'(bus.range_err), 32'(e.rerr));
            chk("in_ready_resp", 32'(bus.in_ready), 32'd0);
            if (h < hold) begin
                @(posedge clk); #1;
                chk("out_valid_hold", 32'(bus.out_valid), 32'd1);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("in_ready_after", 32'(bus.in_ready), 32'd1);
        chk("out_valid_after", 32'(bus.out_valid), 32'd0);
        chk("flags_after", 32'({bus.div_by_zero, bus.range_err}), 32'd0);
    endtask

    initial begin
        int c;
        total = 0;
        bad   = 0;
        model_en        = 1'b1;
        stale_done      = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
        bus.out_ready   = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_div_start", 32'(bus.div_start), 32'd0);
        chk("rst_out_quotient", bus.out_quotient, 32'd0);
        chk("rst_div_m", 32'(bus.div_m), 32'd0);

        run_op(32'd100, 32'd7, 0);
        run_op(32'd55, 32'd0, 0);
        run_op(32'd5, 32'd9, 0);
        run_op(32'h8000_0000, 32'd3, 0);
        run_op(32'd1000, 32'd10, 3);

        // Abandon a division in WAIT with a one-cycle reset
        model_en = 1'b0;
        bus.in_valid    = 1'b1;
        bus.in_dividend = 32'd200;
        bus.in_divisor  = 32'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        c = 0;
        while (c < 100 && !bus.div_start) begin
            @(posedge clk); #1;
            c++;
        end
        chk("rst_test_launch", 32'(bus.div_start), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst2_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst2_div_start", 32'(bus.div_start), 32'd0);
        chk("rst2_flags", 32'({bus.div_by_zero, bus.range_err}), 32'd0);
        chk("rst2_out_quotient", bus.out_quotient, 32'd0);
        chk("rst2_out_rem", bus.out_rem, 32'd0);
        chk("rst2_div_mn", 32'({bus.div_m, bus.div_n}), 32'd0);
        chk("rst2_div_dividend", bus.div_dividend, 32'd0);
        chk("rst2_div_divisor", bus.div_divisor, 32'd0);
        stale_done = 1'b1;
        @(posedge clk); #1;
        stale_done = 1'b0;
        chk("stale_out_valid", 32'(bus.out_valid), 32'd0);
        chk("stale_in_ready", 32'(bus.in_ready), 32'd1);
        chk("stale_out_quotient", bus.out_quotient, 32'd0);
        model_en = 1'b1;

        run_op(32'd81, 32'd9, 0);
        run_op(32'h7FFF_FFFF, 32'h4000_0000, 1);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, b;
            a = $urandom & 32'h7FFF_FFFF;
            b = ($urandom >> $urandom_range(4, 30)) | 32'd1;
            run_op(a, b, i % 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_launch_ctrl.md
# div_launch_ctrl

Front-end controller for the non-restoring sequential divider. Accepts raw 32-bit operand pairs over a valid/ready handshake and finds the leading-one positions `m` (dividend) and `n` (divisor) by sequential shifting. Screens out special cases, issues the one-cycle start pulse and operands to the divider, then holds the divider's quotient/remainder on a valid/ready result port. Sits directly upstream of the divider and owns its launch and completion.

## Interface
- `W`, 32: operand width; fixed at 32 to match the divider.
- `LW`, 5: width of the `m`/`n` bit-index fields.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block idle; can accept a pair.
- `in_dividend` in W: unsigned dividend.
- `in_divisor` in W: unsigned divisor.
- `div_start` out 1: one-cycle launch pulse to the divider's start input.
- `div_dividend` out W: dividend to the divider; stable from launch until `div_done`.
- `div_divisor` out W: divisor to the divider; stable from launch until `div_done`.
- `div_m` out LW: MSB index of the dividend; stable from launch until `div_done`.
- `div_n` out LW: MSB index of the divisor; stable from launch until `div_done`.
- `div_done` in 1: divider completion pulse.
- `div_quotient` in W: divider quotient, sampled when `div_done` = 1.
- `div_rem` in W: divider remainder (signed), sampled when `div_done` = 1.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_quotient` out W: result quotient.
- `out_rem` out W: result remainder.
- `div_by_zero` out 1: result flag, divisor was 0.
- `range_err` out 1: result flag, dividend[31] set (exceeds the divider's signed remainder range).

## Operation
- FSM states: IDLE, SCAN, LAUNCH, WAIT, RESP. `in_ready` = (state == IDLE).
- **IDLE**
  - On `in_valid && in_ready`, capture both operands into working and held registers, and set `m` = `n` = 31.
  - Special cases, evaluated on the captured values in priority order:
    1. divisor == 0: go to RESP with `div_by_zero` = 1, quotient = 0xFFFF_FFFF, remainder = dividend.
    2. dividend[31] == 1: go to RESP with `range_err` = 1, quotient = 0, remainder = dividend.
    3. dividend < divisor (unsigned; includes dividend == 0): go to RESP with quotient = 0, remainder = dividend.
  - Otherwise go to SCAN.
- **SCAN** (each cycle)
  - Dividend: if working bit 31 is 0, shift the working copy left by 1 and decrement `m`.
  - Divisor: same rule, using its own working copy and `n`.
  - When both bit 31 are 1 in the same cycle, go to LAUNCH.
  - Both operands are nonzero here, so the scan terminates.
  - The invariant m ≥ n holds on exit.
- **LAUNCH**
  - `div_start` = 1 for exactly one cycle.
  - `div_dividend` and `div_divisor` carry the held (unshifted) operands.
  - Go to WAIT.
- **WAIT**
  - On `div_done` = 1, register `div_quotient` and `div_rem` into the result registers, then go to RESP.
  - `div_done` in any other state is ignored.
- **RESP**
  - `out_valid` = 1; the result and flags are held stable.
  - On `out_ready`, clear the flags and go to IDLE.
  - No new acceptance occurs in the same cycle as the result handshake.
- **Reset**, from any state including mid-SCAN or WAIT:
  - State goes to IDLE.
  - `div_start`, `out_valid`, `div_by_zero` and `range_err` go to 0.
  - `out_quotient`, `out_rem`, `div_m`, `div_n`, `div_dividend` and `div_divisor` go to 0.
  - A stale `div_done` from an abandoned division arrives in IDLE and is ignored.

## Timing
- Acceptance edge is cycle 0.
- Special cases: `out_valid` = 1 in cycle 1.
- Normal path:
  - SCAN occupies cycles 1..S, where S = max(31−m, 31−n) + 1.
  - `div_start` is high in cycle S+1.
- `out_valid` rises the cycle after `div_done` is sampled high.
- The divider latency is not assumed; WAIT has no timeout.
- `div_m`, `div_n`, `div_dividend` and `div_divisor` hold from LAUNCH through the `div_done` cycle.
- Throughput: one operation in flight.

## Structure
- Shared package `div_pkg` holds:
  - the state enum `div_launch_state_t`;
  - `DIV_W` = 32 and `DIV_LW` = 5;
  - constant `DIV_ZERO_Q` = 32'hFFFF_FFFF.
- One sub-module, `msb_scan`: a single-operand shift-and-decrement leading-one finder with `load`, `step` and `found` signals, instantiated twice.
- The FSM, special-case screening and result registers live in the top module.

## Test plan
1. **Normal division.** 100 / 7, divider model attached.
   - `div_m` = 6, `div_n` = 2.
   - `div_start` in cycle 31 (S = 30).
   - `out_quotient` = 14, `out_rem` = 2.
2. **Divide by zero.** 55 / 0.
   - `out_valid` in cycle 1, `div_by_zero` = 1, quotient = 0xFFFF_FFFF, rem = 55.
   - `div_start` never pulses.
3. **Bypass and range error.**
   - 5 / 9: quotient 0, rem 5 in cycle 1, no launch.
   - 0x8000_0000 / 3: `range_err` = 1, no launch.
4. **Result backpressure.** 1000 / 10 with `out_ready` held low 3 cycles.
   - Result (100, 0) stays stable.
   - `in_ready` stays 0 until the handshake cycle + 1.
5. **Reset mid-WAIT.** Assert `rst` one cycle during WAIT, then inject the late `div_done`.
   - After reset, all outputs are 0.
   - The late `div_done` is ignored.
   - The next operation 81 / 9 returns (9, 0).
6. **Equal MSB positions.** 0x7FFF_FFFF / 0x4000_0000.
   - `div_m` = `div_n` = 30, S = 2.
   - Result (1, 0x3FFF_FFFF).
